// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode constants, receiver state encoding and
// a parameter-legality check used by the receiver (and the transmitter later).
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  function automatic bit uart_params_ok(input int unsigned data_bits,
                                        input int unsigned clks_per_bit,
                                        input int unsigned parity,
                                        input int unsigned stop_bits,
                                        input int unsigned sync_stages);
    return (data_bits >= 5) && (data_bits <= 9) &&
           (clks_per_bit >= 4) && (clks_per_bit % 2 == 0) &&
           (parity <= PARITY_EVEN) &&
           (stop_bits == 1 || stop_bits == 2) &&
           (sync_stages >= 2);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// N-stage synchroniser for an asynchronous single-bit input.
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset; all stages load RST_VAL
//   i_async  asynchronous input
//   o_sync   synchronised output (STAGES cycles of latency)
module uart_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= {STAGES{RST_VAL}};
    else        r_sync <= {r_sync[STAGES-2:0], i_async};
  end

  assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rx_os.sv
// UART receiver with mid-bit sampling from an internal baud counter,
// configurable data width / parity / stop bits, error flags and a
// valid/ready holding register.
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   rx           asynchronous serial line, idle high
//   data         held received word (LSB received first)
//   valid        held word available; popped by valid && ready
//   ready        consumer accept
//   frame_err    held word had a low stop bit
//   parity_err   held word failed parity
//   overrun      one-cycle pulse when a completed frame was dropped
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  if (!uart_params_ok(DATA_BITS, CLKS_PER_BIT, PARITY, STOP_BITS, SYNC_STAGES)) begin : g_param_check
    $error("uart_rx_os: illegal parameter set");
  end

  localparam int unsigned      CW            = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]    CNT_LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]    CNT_HALF      = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]       IDX_DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       IDX_STOP_LAST = 4'(STOP_BITS - 1);

  logic                 w_rx_s;
  rx_state_t            r_state, w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [3:0]           r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_ferr, r_perr;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid, r_frame_err, r_parity_err, r_overrun;

  logic w_bit_tick, w_cnt_clr, w_frame_start, w_shift_en, w_par_en;
  logic w_stop_en, w_commit, w_idx_clr, w_par_bad;

  uart_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (rx),
    .o_sync  (w_rx_s)
  );

  assign w_bit_tick = (r_cnt == CNT_LAST);
  assign w_idx_clr  = w_frame_start || (w_shift_en && r_idx == IDX_DATA_LAST);
  assign w_par_bad  = (PARITY == PARITY_ODD) ? ~(^{r_shift, w_rx_s}) : (^{r_shift, w_rx_s});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_clr     = 1'b0;
    w_frame_start = 1'b0;
    w_shift_en    = 1'b0;
    w_par_en      = 1'b0;
    w_stop_en     = 1'b0;
    w_commit      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = ST_START;
          w_cnt_clr   = 1'b1;
        end
      end
      ST_START: begin
        if (r_cnt == CNT_HALF) begin
          if (w_rx_s) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt   = ST_DATA;
            w_cnt_clr     = 1'b1;
            w_frame_start = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (w_bit_tick) begin
          w_shift_en = 1'b1;
          if (r_idx == IDX_DATA_LAST)
            w_state_nxt = (PARITY != PARITY_NONE) ? ST_PAR : ST_STOP;
        end
      end
      ST_PAR: begin
        if (w_bit_tick) begin
          w_par_en    = 1'b1;
          w_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_bit_tick) begin
          w_stop_en = 1'b1;
          if (r_idx == IDX_STOP_LAST) begin
            w_commit    = 1'b1;
            w_state_nxt = w_rx_s ? ST_IDLE : ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (w_rx_s) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Baud counter, bit index and per-frame accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      if (w_cnt_clr || w_bit_tick) r_cnt <= '0;
      else                         r_cnt <= r_cnt + CW'(1);

      if (w_idx_clr)                    r_idx <= '0;
      else if (w_shift_en || w_stop_en) r_idx <= r_idx + 4'd1;

      if (w_shift_en) r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};

      if (w_frame_start)             r_ferr <= 1'b0;
      else if (w_stop_en && !w_rx_s) r_ferr <= 1'b1;

      if (w_frame_start) r_perr <= 1'b0;
      else if (w_par_en) r_perr <= w_par_bad;
    end
  end

  // Holding register: a commit always wins over a plain pop; the stop sample
  // in the commit cycle is folded into the frame error directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_commit) begin
        if (!r_valid || ready) begin
          r_data       <= r_shift;
          r_frame_err  <= r_ferr | ~w_rx_s;
          r_parity_err <= r_perr;
          r_valid      <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data       = r_data;
  assign valid      = r_valid;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_os.sv
module tb_uart_rx_os;

  localparam int unsigned CPB0 = 16;
  localparam int unsigned CPB1 = 4;
  localparam int unsigned SYNC = 2;
  localparam int unsigned N0   = 10;  // start + 8 data + stop
  localparam int unsigned N1   = 11;  // start + 8 data + parity + stop

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx0 = 1'b1, rx1 = 1'b1, ready0 = 1'b1, ready1 = 1'b1;
  logic [7:0] data0, data1;
  logic valid0, valid1, ferr0, ferr1, perr0, perr1, ov0, ov1;

  int total = 0;
  int bad = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_os #(.DATA_BITS(8), .CLKS_PER_BIT(CPB0), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(SYNC)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .rx(rx0), .data(data0), .valid(valid0), .ready(ready0),
    .frame_err(ferr0), .parity_err(perr0), .overrun(ov0)
  );

  uart_rx_os #(.DATA_BITS(8), .CLKS_PER_BIT(CPB1), .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(SYNC)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rx(rx1), .data(data1), .valid(valid1), .ready(ready1),
    .frame_err(ferr1), .parity_err(perr1), .overrun(ov1)
  );

  // Observers: log each newly presented word, overrun pulses and valid-high cycles.
  logic [7:0]  m0_data[$], m1_data[$];
  bit          m0_ferr[$], m0_perr[$], m1_ferr[$], m1_perr[$];
  int unsigned m0_cyc[$], m1_cyc[$];
  int unsigned m0_ov = 0, m0_ov_cyc = 0, m0_vhi = 0, m1_ov = 0;
  bit          p0_take = 1'b1, p1_take = 1'b1;

  always @(negedge clk) begin
    if (valid0 && p0_take) begin
      m0_data.push_back(data0); m0_ferr.push_back(ferr0);
      m0_perr.push_back(perr0); m0_cyc.push_back(cyc);
    end
    if (valid0) m0_vhi++;
    if (ov0) begin m0_ov++; m0_ov_cyc = cyc; end
    p0_take = !valid0 || ready0;
  end

  always @(negedge clk) begin
    if (valid1 && p1_take) begin
      m1_data.push_back(data1); m1_ferr.push_back(ferr1);
      m1_perr.push_back(perr1); m1_cyc.push_back(cyc);
    end
    if (ov1) m1_ov++;
    p1_take = !valid1 || ready1;
  end

  // Reference model: frame bit patterns (LSB first, start bit in bit 0) and latency.
  function automatic logic [15:0] frame8n1(input logic [7:0] d);
    return {6'b0, 1'b1, d, 1'b0};
  endfunction

  function automatic logic [15:0] frame8e1(input logic [7:0] d, input bit wrong_par);
    return {5'b0, 1'b1, (^d) ^ wrong_par, d, 1'b0};
  endfunction

  function automatic int unsigned latency(input int unsigned cpb, input int unsigned n);
    return SYNC + cpb / 2 + (n - 1) * cpb + 1;
  endfunction

  task automatic clear_mon();
    m0_data.delete(); m0_ferr.delete(); m0_perr.delete(); m0_cyc.delete();
    m1_data.delete(); m1_ferr.delete(); m1_perr.delete(); m1_cyc.delete();
    m0_ov = 0; m0_vhi = 0; m1_ov = 0;
  endtask

  task automatic send_bits(input int unsigned which, input logic [15:0] bits,
                           input int unsigned nb, output int unsigned t0);
    int unsigned cpb;
    cpb = (which == 0) ? CPB0 : CPB1;
    t0 = 0;
    for (int unsigned i = 0; i < nb; i++) begin
      @(posedge clk); #1;
      if (i == 0) t0 = cyc;
      if (which == 0) rx0 = bits[i]; else rx1 = bits[i];
      repeat (cpb - 1) @(posedge clk);
    end
    @(posedge clk); #1;
    if (which == 0) rx0 = 1'b1; else rx1 = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (data0 !== 8'h00) begin bad++; $display("FAIL reset_data0: got %h want 00", data0); end
    total++; if (valid0 !== 1'b0) begin bad++; $display("FAIL reset_valid0: got %b want 0", valid0); end
    total++; if (ferr0 !== 1'b0 || perr0 !== 1'b0) begin bad++; $display("FAIL reset_err0: got %b%b want 00", ferr0, perr0); end
    total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL reset_ov0: got %b want 0", ov0); end
    total++; if (valid1 !== 1'b0 || data1 !== 8'h00) begin bad++; $display("FAIL reset_dut1: got v=%b d=%h want 0/00", valid1, data1); end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_8n1();
    int unsigned t0;
    logic [7:0] d;
    clear_mon(); ready0 = 1'b1;
    send_bits(0, frame8n1(8'hA5), N0, t0);
    repeat (4) @(posedge clk); @(negedge clk);
    total++; if (m0_data.size() != 1) begin bad++; $display("FAIL a5_count: got %0d want 1", m0_data.size()); end
    if (m0_data.size() >= 1) begin
      total++; if (m0_data[0] !== 8'hA5) begin bad++; $display("FAIL a5_data: got %h want a5", m0_data[0]); end
      total++; if (m0_ferr[0] !== 1'b0 || m0_perr[0] !== 1'b0) begin bad++; $display("FAIL a5_err: got %b%b want 00", m0_ferr[0], m0_perr[0]); end
      total++; if (m0_cyc[0] != t0 + latency(CPB0, N0)) begin bad++; $display("FAIL a5_time: got %0d want %0d", m0_cyc[0], t0 + latency(CPB0, N0)); end
    end
    total++; if (m0_vhi != 1) begin bad++; $display("FAIL a5_valid_width: got %0d want 1", m0_vhi); end
    for (int unsigned k = 0; k < 6; k++) begin
      clear_mon();
      d = 8'($urandom);
      repeat ($urandom_range(0, 20)) @(posedge clk);
      send_bits(0, frame8n1(d), N0, t0);
      repeat (4) @(posedge clk); @(negedge clk);
      total++;
      if (m0_data.size() != 1 || m0_data[0] !== d || m0_ferr[0] !== 1'b0 || m0_perr[0] !== 1'b0) begin
        bad++; $display("FAIL rand8n1: got n=%0d d=%h want n=1 d=%h", m0_data.size(), data0, d);
      end
    end
  endtask

  task automatic test_parity();
    int unsigned t0;
    logic [7:0] d;
    bit wp;
    clear_mon(); ready1 = 1'b1;
    send_bits(1, frame8e1(8'h3C, 1'b1), N1, t0);
    repeat (8) @(posedge clk); @(negedge clk);
    total++; if (m1_data.size() != 1) begin bad++; $display("FAIL par3c_count: got %0d want 1", m1_data.size()); end
    if (m1_data.size() >= 1) begin
      total++; if (m1_data[0] !== 8'h3C) begin bad++; $display("FAIL par3c_data: got %h want 3c", m1_data[0]); end
      total++; if (m1_perr[0] !== 1'b1) begin bad++; $display("FAIL par3c_perr: got %b want 1", m1_perr[0]); end
      total++; if (m1_ferr[0] !== 1'b0) begin bad++; $display("FAIL par3c_ferr: got %b want 0", m1_ferr[0]); end
      total++; if (m1_cyc[0] != t0 + latency(CPB1, N1)) begin bad++; $display("FAIL par3c_time: got %0d want %0d", m1_cyc[0], t0 + latency(CPB1, N1)); end
    end
    for (int unsigned k = 0; k < 8; k++) begin
      clear_mon();
      d  = 8'($urandom);
      wp = 1'($urandom);
      repeat ($urandom_range(0, 6)) @(posedge clk);
      send_bits(1, frame8e1(d, wp), N1, t0);
      repeat (8) @(posedge clk); @(negedge clk);
      total++;
      if (m1_data.size() != 1 || m1_data[0] !== d || m1_perr[0] !== wp || m1_ferr[0] !== 1'b0) begin
        bad++; $display("FAIL rand_par: got n=%0d d=%h pe=%b want n=1 d=%h pe=%b", m1_data.size(), data1, perr1, d, wp);
      end
    end
    total++; if (m1_ov != 0) begin bad++; $display("FAIL par_overrun: got %0d want 0", m1_ov); end
  endtask

  task automatic test_overrun();
    int unsigned ta, tb;
    clear_mon(); ready0 = 1'b0;
    send_bits(0, frame8n1(8'h11), N0, ta);
    send_bits(0, frame8n1(8'h22), N0, tb);
    repeat (4) @(posedge clk); @(negedge clk);
    total++; if (valid0 !== 1'b1 || data0 !== 8'h11) begin bad++; $display("FAIL ovr_hold: got v=%b d=%h want 1/11", valid0, data0); end
    total++; if (m0_ov != 1) begin bad++; $display("FAIL ovr_count: got %0d want 1", m0_ov); end
    total++; if (m0_ov_cyc != tb + latency(CPB0, N0)) begin bad++; $display("FAIL ovr_time: got %0d want %0d", m0_ov_cyc, tb + latency(CPB0, N0)); end
    total++; if (m0_data.size() != 1) begin bad++; $display("FAIL ovr_words: got %0d want 1", m0_data.size()); end
    @(posedge clk); #1 ready0 = 1'b1;
    @(negedge clk);
    total++; if (valid0 !== 1'b1) begin bad++; $display("FAIL pop_before: got %b want 1", valid0); end
    @(posedge clk); @(negedge clk);
    total++; if (valid0 !== 1'b0) begin bad++; $display("FAIL pop_after: got %b want 0", valid0); end
    total++; if (data0 !== 8'h11) begin bad++; $display("FAIL pop_data_kept: got %h want 11", data0); end
  endtask

  task automatic test_glitch();
    int unsigned t0;
    clear_mon(); ready0 = 1'b1;
    @(posedge clk); #1 rx0 = 1'b0;
    repeat (CPB0 / 2 - 1) @(posedge clk);
    #1 rx0 = 1'b1;
    repeat (2 * N0 * CPB0) @(posedge clk); @(negedge clk);
    total++; if (m0_data.size() != 0 || m0_ov != 0) begin bad++; $display("FAIL glitch: got words=%0d ov=%0d want 0/0", m0_data.size(), m0_ov); end
    send_bits(0, frame8n1(8'h55), N0, t0);
    repeat (4) @(posedge clk); @(negedge clk);
    total++;
    if (m0_data.size() != 1 || m0_data[0] !== 8'h55 || m0_ferr[0] !== 1'b0) begin
      bad++; $display("FAIL after_glitch: got n=%0d d=%h want n=1 d=55", m0_data.size(), data0);
    end
  endtask

  task automatic test_break();
    int unsigned t0;
    clear_mon(); ready0 = 1'b1;
    @(posedge clk); #1 rx0 = 1'b0;
    repeat (3 * N0 * CPB0) @(posedge clk); @(negedge clk);
    total++; if (m0_data.size() != 1) begin bad++; $display("FAIL brk_count: got %0d want 1", m0_data.size()); end
    if (m0_data.size() >= 1) begin
      total++; if (m0_data[0] !== 8'h00 || m0_ferr[0] !== 1'b1 || m0_perr[0] !== 1'b0) begin
        bad++; $display("FAIL brk_word: got d=%h fe=%b pe=%b want 00/1/0", m0_data[0], m0_ferr[0], m0_perr[0]);
      end
    end
    #1 rx0 = 1'b1;
    repeat (20) @(posedge clk);
    send_bits(0, frame8n1(8'h7E), N0, t0);
    repeat (4) @(posedge clk); @(negedge clk);
    total++;
    if (m0_data.size() != 2 || m0_data[1] !== 8'h7E || m0_ferr[1] !== 1'b0) begin
      bad++; $display("FAIL after_brk: got n=%0d d=%h fe=%b want n=2 d=7e fe=0", m0_data.size(), data0, ferr0);
    end
  endtask

  task automatic test_reset_mid();
    int unsigned t0;
    clear_mon(); ready0 = 1'b0;
    send_bits(0, frame8n1(8'hE7), N0, t0);
    repeat (4) @(posedge clk);
    @(posedge clk); #1 rx0 = 1'b0;
    repeat (CPB0) @(posedge clk); #1 rx0 = 1'b1;
    repeat (CPB0 + 10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (data0 !== 8'h00 || valid0 !== 1'b0) begin bad++; $display("FAIL rst_mid_out: got v=%b d=%h want 0/00", valid0, data0); end
    total++; if (ferr0 !== 1'b0 || perr0 !== 1'b0 || ov0 !== 1'b0) begin bad++; $display("FAIL rst_mid_flags: got %b%b%b want 000", ferr0, perr0, ov0); end
    rx0 = 1'b1; ready0 = 1'b1;
    repeat (3) @(posedge clk); #1 rst_n = 1'b1;
    repeat (N0 * CPB0) @(posedge clk);
    clear_mon();
    send_bits(0, frame8n1(8'hC3), N0, t0);
    repeat (4) @(posedge clk); @(negedge clk);
    total++;
    if (m0_data.size() != 1 || m0_data[0] !== 8'hC3 || m0_ferr[0] !== 1'b0 || m0_perr[0] !== 1'b0) begin
      bad++; $display("FAIL after_rst: got n=%0d d=%h want n=1 d=c3", m0_data.size(), data0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] sent[4];
    logic [7:0] got[$];
    int unsigned w;
    clear_mon(); ready0 = 1'b0;
    foreach (sent[i]) sent[i] = 8'($urandom);
    fork
      begin
        int unsigned t;
        for (int i = 0; i < 4; i++) send_bits(0, frame8n1(sent[i]), N0, t);
      end
      begin
        for (int i = 0; i < 4; i++) begin
          w = 0;
          @(negedge clk);
          while (!valid0 && w < 400) begin @(negedge clk); w++; end
          if (!valid0) begin
            total++; bad++; $display("FAIL b2b_timeout: got no word %0d want valid", i);
            break;
          end
          got.push_back(data0);
          #1 ready0 = 1'b1;
          @(posedge clk); #1 ready0 = 1'b0;
        end
      end
    join
    repeat (4) @(posedge clk); @(negedge clk);
    total++; if (got.size() != 4) begin bad++; $display("FAIL b2b_count: got %0d want 4", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      total++; if (got[i] !== sent[i]) begin bad++; $display("FAIL b2b_data%0d: got %h want %h", i, got[i], sent[i]); end
    end
    total++; if (m0_ov != 0 || valid0 !== 1'b0) begin bad++; $display("FAIL b2b_end: got ov=%0d v=%b want 0/0", m0_ov, valid0); end
    ready0 = 1'b1;
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_overrun();
    test_glitch();
    test_break();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
